wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter MMIO_TIMEOUT, default 16, max cycles spent in MMIO_WAIT before forced completion.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ex_valid_i  input  1  EX-stage instruction valid.
REQ-005 ex_reg_we_i  input  1  instruction writes rd.
REQ-006 ex_rd_i  input  5  destination register.
REQ-007 ex_wb_sel_i  input  2  00 ALU, 01 load, 10 PC+4; 11 treated as ALU.
REQ-008 ex_funct3_i  input  3  load width/sign code.
REQ-009 ex_alu_result_i  input  32  ALU result / load address.
REQ-010 ex_pc_plus4_i  input  32  PC+4 for JAL/JALR.
REQ-011 id_rs1_i, id_rs2_i  input  5 each  ID-stage source registers.
REQ-012 id_use_rs1_i, id_use_rs2_i  input  1 each  source actually read.
REQ-013 dmem_rdata_i, bios_rdata_i  input  32 each  synchronous-RAM read data, valid the cycle after address.
REQ-014 mmio_ready_i  input  1; mmio_rdata_i  input  32  MMIO read completion and data.
REQ-015 mmio_req_o  output  1  MMIO read request held until completion.
REQ-016 wb_we_o  output  1; wb_addr_o  output  5; wb_data_o  output  32  register-file write port.
REQ-017 stall_o  output  1  hold IF/ID/EX this cycle.
REQ-018 err_o  output  1  sticky MMIO timeout flag.

Function
REQ-019 WB register (valid, we, rd, wb_sel, funct3, alu_result, pc_plus4) SHALL load from EX each cycle unless mmio_busy; load-use stall alone SHALL NOT hold it.
REQ-020 Load source decode on WB alu_result[31:28]: 4'b00x1 DMEM, 4'b0100 BIOS, 4'b1000 MMIO; any other value returns data 0.
REQ-021 Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW full word; lane chosen by alu_result[1:0]; misaligned LH/LW use word-aligned lane, no trap.
REQ-022 wb_data_o SHALL be ALU result, extended load data, or PC+4 per wb_sel.
REQ-023 wb_we_o = WB valid & we & (rd != 0) & not-waiting; wb_addr_o = WB rd at all times.
REQ-024 FSM states IDLE, MMIO_WAIT; IDLE with WB valid MMIO load -> MMIO_WAIT, mmio_req_o=1, wb_we_o=0, stall_o=1.
REQ-025 MMIO_WAIT: mmio_req_o=1; mmio_ready_i=1 -> wb_we_o=1 with extended mmio_rdata_i, stall_o=0, next IDLE.
REQ-026 Timeout counter SHALL clear on MMIO_WAIT entry, increment each wait cycle; at MMIO_TIMEOUT-1 without ready -> write 0, set err_o, next IDLE.
REQ-027 ready and timeout in same cycle: ready wins, no err_o.
REQ-028 mmio_busy = (IDLE & WB MMIO load) | (MMIO_WAIT & ~mmio_ready_i & ~timeout).
REQ-029 load_use = ex_valid_i & ex_reg_we_i & ex_wb_sel_i==01 & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
REQ-030 stall_o = load_use | mmio_busy.
REQ-031 Back-to-back MMIO loads SHALL each complete separately, no lost write.

Reset
REQ-032 rst SHALL force IDLE, WB valid 0, counter 0, err_o 0; all outputs 0 the cycle after rst.
REQ-033 rst during MMIO_WAIT SHALL abandon the access: no write, mmio_req_o 0 next cycle.

Structure
REQ-034 Shared package SHALL hold wb_sel encodings, region nibbles, load funct3 codes, FSM state encoding.
REQ-035 Combinational sub-module load_ext (funct3, byte offset, word -> 32-bit result) SHALL be used for all load data.

Verification
REQ-036 LB addr 0x10000003, DMEM word 0x80FF_1234 -> wb_data 0xFFFF_FF80, wb_we 1, one cycle.
REQ-037 LHU addr 0x40000002, BIOS word 0xBEEF_0000 -> wb_data 0x0000_BEEF.
REQ-038 LW x5 in EX, ID reads rs2=x5 -> stall_o 1 one cycle; rd=x0 case -> stall_o 0.
REQ-039 LW addr 0x80000000, ready at 3rd wait cycle, rdata 0x1234_5678 -> mmio_req held 3 cycles, stall_o until ready, single write 0x1234_5678.
REQ-040 MMIO load never ready, MMIO_TIMEOUT=16 -> write 0 after 16 wait cycles, err_o 1 until rst.
REQ-041 rst asserted 2nd wait cycle -> no write, mmio_req_o 0, state IDLE next cycle.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the write-back controller.
// Holds the wb_sel encodings, address-region nibbles, load funct3 codes,
// the FSM state type and a helper that decodes the load source region.
package wb_ctrl_pkg;

    // Write-back source select; 2'b11 is treated as ALU.
    localparam logic [1:0] WbSelAlu  = 2'b00;
    localparam logic [1:0] WbSelLoad = 2'b01;
    localparam logic [1:0] WbSelPc4  = 2'b10;

    // Region nibbles on address bits [31:28]. DMEM matches 4'b00x1.
    localparam logic [3:0] RegionDmemA = 4'b0001;
    localparam logic [3:0] RegionDmemB = 4'b0011;
    localparam logic [3:0] RegionBios  = 4'b0100;
    localparam logic [3:0] RegionMmio  = 4'b1000;

    // Load funct3 codes.
    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    typedef enum logic {
        StIdle     = 1'b0,
        StMmioWait = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SrcNone = 2'b00,
        SrcDmem = 2'b01,
        SrcBios = 2'b10,
        SrcMmio = 2'b11
    } src_e;

    function automatic src_e decode_region(input logic [3:0] nib);
        src_e src;
        if ((nib == RegionDmemA) || (nib == RegionDmemB)) begin
            src = SrcDmem;
        end else if (nib == RegionBios) begin
            src = SrcBios;
        end else if (nib == RegionMmio) begin
            src = SrcMmio;
        end else begin
            src = SrcNone;
        end
        return src;
    endfunction

endpackage

// File: rtl/wb_ctrl_load_ext.sv
// Load data extraction and extension.
// Ports:
//   funct3_i  load width/sign code
//   offset_i  byte offset (address bits [1:0])
//   word_i    32-bit word read from memory
//   data_o    extended 32-bit load result
// Misaligned halfword/word accesses select the aligned lane; no trap.
module wb_ctrl_load_ext
    import wb_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (offset_i)
            2'd0: w_byte = word_i[7:0];
            2'd1: w_byte = word_i[15:8];
            2'd2: w_byte = word_i[23:16];
            2'd3: w_byte = word_i[31:24];
            default: w_byte = word_i[7:0];
        endcase
        // Bit 0 of the offset is ignored for halfwords.
        w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3Lb:    data_o = {{24{w_byte[7]}}, w_byte};
            F3Lbu:   data_o = {24'd0, w_byte};
            F3Lh:    data_o = {{16{w_half[15]}}, w_half};
            F3Lhu:   data_o = {16'd0, w_half};
            F3Lw:    data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back stage controller.
// Registers the EX-stage result, selects ALU / load / PC+4 data for the
// register file, waits for MMIO reads with a timeout, and raises stalls for
// load-use hazards and outstanding MMIO reads.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_*                           EX-stage instruction fields
//   id_rs1_i/id_rs2_i, id_use_*    ID-stage source registers and usage
//   dmem_rdata_i, bios_rdata_i     synchronous RAM read data (WB cycle)
//   mmio_ready_i, mmio_rdata_i     MMIO completion and read data
//   mmio_req_o                     MMIO read request
//   wb_we_o, wb_addr_o, wb_data_o  register-file write port
//   stall_o                        hold IF/ID/EX
//   err_o                          sticky MMIO timeout flag
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int unsigned MMIO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_reg_we_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [1:0]  ex_wb_sel_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_pc_plus4_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic [31:0] bios_rdata_i,
    input  logic        mmio_ready_i,
    input  logic [31:0] mmio_rdata_i,
    output logic        mmio_req_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int unsigned CntW = (MMIO_TIMEOUT > 1) ? $clog2(MMIO_TIMEOUT) : 1;

    // WB pipeline register
    logic        r_valid;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [1:0]  r_wb_sel;
    logic [2:0]  r_funct3;
    logic [31:0] r_alu;
    logic [31:0] r_pc4;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_err, w_err_d;

    logic        w_mmio_load;
    logic        w_timeout;
    logic        w_busy;
    logic        w_waiting;
    logic        w_force_zero;
    logic        w_load_use;
    src_e        w_src;
    logic [31:0] w_word;
    logic [31:0] w_ext;

    assign w_src       = decode_region(r_alu[31:28]);
    assign w_mmio_load = r_valid & (r_wb_sel == WbSelLoad) & (w_src == SrcMmio);
    assign w_timeout   = (r_cnt == CntW'(MMIO_TIMEOUT - 1));

    always_comb begin
        w_word = 32'd0;
        case (w_src)
            SrcDmem: w_word = dmem_rdata_i;
            SrcBios: w_word = bios_rdata_i;
            SrcMmio: w_word = mmio_rdata_i;
            default: w_word = 32'd0;
        endcase
    end

    wb_ctrl_load_ext u_load_ext (
        .funct3_i (r_funct3),
        .offset_i (r_alu[1:0]),
        .word_i   (w_word),
        .data_o   (w_ext)
    );

    // FSM next state and MMIO handshake outputs
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_err_d      = r_err;
        w_busy       = 1'b0;
        w_waiting    = 1'b0;
        w_force_zero = 1'b0;
        mmio_req_o   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_mmio_load) begin
                    w_state_d  = StMmioWait;
                    w_cnt_d    = '0;
                    mmio_req_o = 1'b1;
                    w_busy     = 1'b1;
                    w_waiting  = 1'b1;
                end
            end
            StMmioWait: begin
                mmio_req_o = 1'b1;
                if (mmio_ready_i) begin
                    // Ready wins over a coincident timeout.
                    w_state_d = StIdle;
                end else if (w_timeout) begin
                    w_state_d    = StIdle;
                    w_err_d      = 1'b1;
                    w_force_zero = 1'b1;
                end else begin
                    w_cnt_d   = r_cnt + CntW'(1);
                    w_busy    = 1'b1;
                    w_waiting = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        wb_data_o = r_alu;
        case (r_wb_sel)
            WbSelLoad: wb_data_o = w_force_zero ? 32'd0 : w_ext;
            WbSelPc4:  wb_data_o = r_pc4;
            default:   wb_data_o = r_alu;
        endcase
    end

    assign w_load_use = ex_valid_i & ex_reg_we_i & (ex_wb_sel_i == WbSelLoad)
                      & (ex_rd_i != 5'd0)
                      & ((id_use_rs1_i & (id_rs1_i == ex_rd_i))
                       | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

    // Reset abandons any in-flight access, so no write in that cycle.
    assign wb_we_o   = r_valid & r_we & (r_rd != 5'd0) & ~w_waiting & ~rst;
    assign wb_addr_o = r_rd;
    assign stall_o   = w_load_use | w_busy;
    assign err_o     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= 5'd0;
            r_wb_sel <= WbSelAlu;
            r_funct3 <= 3'd0;
            r_alu    <= 32'd0;
            r_pc4    <= 32'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
            // Only an outstanding MMIO read holds WB; load-use stalls do not.
            if (!w_busy) begin
                r_valid  <= ex_valid_i;
                r_we     <= ex_reg_we_i;
                r_rd     <= ex_rd_i;
                r_wb_sel <= ex_wb_sel_i;
                r_funct3 <= ex_funct3_i;
                r_alu    <= ex_alu_result_i;
                r_pc4    <= ex_pc_plus4_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    localparam int Tmo = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_we;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_sel;
    logic [2:0]  ex_f3;
    logic [31:0] ex_alu, ex_pc4;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use1, id_use2;
    logic [31:0] dmem_rdata, bios_rdata, mmio_rdata;
    logic        mmio_ready;
    logic        mmio_req, wb_we, stall, err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_ctrl #(.MMIO_TIMEOUT(Tmo)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid),
        .ex_reg_we_i     (ex_we),
        .ex_rd_i         (ex_rd),
        .ex_wb_sel_i     (ex_sel),
        .ex_funct3_i     (ex_f3),
        .ex_alu_result_i (ex_alu),
        .ex_pc_plus4_i   (ex_pc4),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use1),
        .id_use_rs2_i    (id_use2),
        .dmem_rdata_i    (dmem_rdata),
        .bios_rdata_i    (bios_rdata),
        .mmio_ready_i    (mmio_ready),
        .mmio_rdata_i    (mmio_rdata),
        .mmio_req_o      (mmio_req),
        .wb_we_o         (wb_we),
        .wb_addr_o       (wb_addr),
        .wb_data_o       (wb_data),
        .stall_o         (stall),
        .err_o           (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load extension by shifting and masking the addressed lane.
    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Model of the instruction currently in WB and the MMIO wait status.
    bit          m_known = 0;
    logic        m_valid, m_we;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_pc4;
    bit          m_waiting;
    int          m_wcnt;
    bit          m_err;
    bit          e_busy, e_enter, e_done, e_ready;

    always @(negedge clk) begin
        if (m_known) begin : cmp
            int          nib;
            logic [31:0] word, x_data;
            bit          x_mmio, x_wrok, x_done, x_busy, x_req, x_we, x_lu;
            nib    = int'(m_alu[31:28]);
            x_mmio = m_valid && (m_sel == 2'b01) && (nib == 8);
            x_wrok = m_valid && m_we && (m_rd != 5'd0);
            if (m_waiting) begin
                x_done = mmio_ready || (m_wcnt == Tmo - 1);
                x_busy = !x_done;
                x_req  = 1'b1;
                x_we   = x_wrok && x_done;
                x_data = mmio_ready ? m_ext(m_f3, m_alu[1:0], mmio_rdata) : 32'd0;
            end else begin
                x_done = 1'b0;
                x_busy = x_mmio;
                x_req  = x_mmio;
                x_we   = x_wrok && !x_mmio;
                if (nib == 1 || nib == 3)  word = dmem_rdata;
                else if (nib == 4)         word = bios_rdata;
                else                       word = 32'd0;
                if (m_sel == 2'b01)        x_data = m_ext(m_f3, m_alu[1:0], word);
                else if (m_sel == 2'b10)   x_data = m_pc4;
                else                       x_data = m_alu;
            end
            if (rst) x_we = 1'b0;
            x_lu = ex_valid && ex_we && (ex_sel == 2'b01) && (ex_rd != 5'd0) &&
                   ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
            chk("model_we",    32'(wb_we),    32'(x_we));
            chk("model_addr",  32'(wb_addr),  32'(m_rd));
            chk("model_req",   32'(mmio_req), 32'(x_req));
            chk("model_stall", 32'(stall),    32'(x_lu || x_busy));
            chk("model_err",   32'(err),      32'(m_err));
            if (x_we) chk("model_data", wb_data, x_data);
            e_busy  <= x_busy;
            e_enter <= !m_waiting && x_mmio;
            e_done  <= x_done;
            e_ready <= mmio_ready;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_known   <= 1'b1;
            m_valid   <= 1'b0;
            m_we      <= 1'b0;
            m_rd      <= 5'd0;
            m_sel     <= 2'b00;
            m_f3      <= 3'd0;
            m_alu     <= 32'd0;
            m_pc4     <= 32'd0;
            m_waiting <= 1'b0;
            m_wcnt    <= 0;
            m_err     <= 1'b0;
        end else if (m_known) begin
            if (e_enter) begin
                m_waiting <= 1'b1;
                m_wcnt    <= 0;
            end else if (m_waiting) begin
                if (e_done) begin
                    m_waiting <= 1'b0;
                    if (!e_ready) m_err <= 1'b1;
                end else begin
                    m_wcnt <= m_wcnt + 1;
                end
            end
            if (!e_busy) begin
                m_valid <= ex_valid;
                m_we    <= ex_we;
                m_rd    <= ex_rd;
                m_sel   <= ex_sel;
                m_f3    <= ex_f3;
                m_alu   <= ex_alu;
                m_pc4   <= ex_pc4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_ins(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc4);
        ex_valid = 1'b1;
        ex_we    = 1'b1;
        ex_rd    = rd;
        ex_sel   = sel;
        ex_f3    = f3;
        ex_alu   = alu;
        ex_pc4   = pc4;
    endtask

    task automatic ex_nop();
        ex_valid = 1'b0;
        ex_we    = 1'b0;
        ex_rd    = 5'd0;
        ex_sel   = 2'b00;
        ex_f3    = 3'd0;
        ex_alu   = 32'd0;
        ex_pc4   = 32'd0;
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] word;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[8];
    int   req_n, wr_n, wr_at;
    logic [4:0]  wr_addr[2];
    logic [31:0] wr_data[2];

    initial begin
        rst = 1'b1;
        ex_nop();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        dmem_rdata = 32'd0; bios_rdata = 32'd0; mmio_rdata = 32'd0; mmio_ready = 1'b0;

        vt[0] = '{5'd4,  WbSelLoad, F3Lh,  32'h1000_0002, 32'h0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
        vt[1] = '{5'd4,  WbSelLoad, F3Lbu, 32'h3000_0001, 32'h0, 32'h0000_AB00, 1'b1, 32'h0000_00AB};
        vt[2] = '{5'd4,  WbSelLoad, F3Lw,  32'h1000_0001, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vt[3] = '{5'd4,  WbSelLoad, F3Lh,  32'h4000_0001, 32'h0, 32'h1234_F00F, 1'b1, 32'hFFFF_F00F};
        vt[4] = '{5'd4,  WbSelLoad, F3Lw,  32'h2000_0000, 32'h0, 32'h1234_5678, 1'b1, 32'h0};
        vt[5] = '{5'd9,  WbSelPc4,  F3Lb,  32'h0,         32'h1004, 32'h0,     1'b1, 32'h0000_1004};
        vt[6] = '{5'd9,  2'b11,     F3Lb,  32'hA5A5_A5A5, 32'h4,  32'h0,       1'b1, 32'hA5A5_A5A5};
        vt[7] = '{5'd0,  WbSelAlu,  F3Lb,  32'h0000_0055, 32'h0,  32'h0,       1'b0, 32'h0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_addr", 32'(wb_addr), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_req", 32'(mmio_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // ALU write
        tick(); ex_ins(5'd3, WbSelAlu, 3'd0, 32'hDEAD_BEEF, 32'h100);
        tick(); ex_nop();
        @(negedge clk);
        chk("alu_we", 32'(wb_we), 32'd1);
        chk("alu_addr", 32'(wb_addr), 32'd3);
        chk("alu_data", wb_data, 32'hDEAD_BEEF);

        // LB from DMEM, sign-extended, single-cycle write
        tick(); ex_ins(5'd5, WbSelLoad, F3Lb, 32'h1000_0003, 32'h0);
        tick(); ex_nop(); dmem_rdata = 32'h80FF_1234;
        @(negedge clk);
        chk("lb_we", 32'(wb_we), 32'd1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        tick();
        @(negedge clk);
        chk("lb_one_cycle", 32'(wb_we), 32'd0);

        // LHU from BIOS
        ex_ins(5'd6, WbSelLoad, F3Lhu, 32'h4000_0002, 32'h0);
        tick(); ex_nop(); bios_rdata = 32'hBEEF_0000;
        @(negedge clk);
        chk("lhu_data", wb_data, 32'h0000_BEEF);

        // Extension, alignment, region and select table
        for (int i = 0; i < 8; i++) begin
            tick(); ex_ins(vt[i].rd, vt[i].sel, vt[i].f3, vt[i].alu, vt[i].pc4);
            tick(); ex_nop(); dmem_rdata = vt[i].word; bios_rdata = vt[i].word;
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vt[i].exp_we));
            if (vt[i].exp_we) chk($sformatf("vec%0d_data", i), wb_data, vt[i].exp_data);
        end

        // Load-use hazard on rs2, WB still advances
        tick(); ex_ins(5'd5, WbSelLoad, F3Lw, 32'h1000_0000, 32'h0);
        id_rs2 = 5'd5; id_use2 = 1'b1;
        @(negedge clk);
        chk("lu_rs2_stall", 32'(stall), 32'd1);
        tick(); ex_nop(); id_rs2 = 5'd0; id_use2 = 1'b0; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_wb_we", 32'(wb_we), 32'd1);
        chk("lu_wb_data", wb_data, 32'h1111_2222);
        // rd = x0 never stalls
        tick(); ex_ins(5'd0, WbSelLoad, F3Lw, 32'h1000_0000, 32'h0);
        id_rs2 = 5'd0; id_use2 = 1'b1;
        @(negedge clk);
        chk("lu_x0_stall", 32'(stall), 32'd0);
        // rs1 match counts only when rs1 is used
        tick(); ex_ins(5'd9, WbSelLoad, F3Lw, 32'h1000_0000, 32'h0);
        id_use2 = 1'b0; id_rs1 = 5'd9; id_use1 = 1'b1;
        @(negedge clk);
        chk("lu_rs1_stall", 32'(stall), 32'd1);
        tick(); id_use1 = 1'b0;
        @(negedge clk);
        chk("lu_rs1_unused", 32'(stall), 32'd0);
        tick(); ex_nop(); id_rs1 = 5'd0;

        // MMIO LW, ready on the third request cycle
        tick(); ex_ins(5'd7, WbSelLoad, F3Lw, 32'h8000_0000, 32'h0);
        tick(); ex_nop();
        req_n = 0; wr_n = 0;
        for (int c = 1; c <= 6; c++) begin
            mmio_ready = (c == 3);
            mmio_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
            @(negedge clk);
            if (mmio_req) req_n++;
            if (wb_we) begin
                wr_n++;
                chk("mmio_data", wb_data, 32'h1234_5678);
            end
            if (c < 3) chk("mmio_stall", 32'(stall), 32'd1);
            tick();
        end
        mmio_ready = 1'b0;
        chk("mmio_req_cycles", 32'(req_n), 32'd3);
        chk("mmio_writes", 32'(wr_n), 32'd1);

        // MMIO timeout: detect cycle plus 16 wait cycles, then write 0
        ex_ins(5'd8, WbSelLoad, F3Lw, 32'h8000_0010, 32'h0);
        tick(); ex_nop();
        wr_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (wb_we) begin
                wr_at = c;
                chk("tmo_data", wb_data, 32'd0);
            end
            tick();
        end
        @(negedge clk);
        chk("tmo_write_cycle", 32'(wr_at), 32'd17);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_req_low", 32'(mmio_req), 32'd0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("tmo_err_cleared", 32'(err), 32'd0);

        // Back-to-back MMIO loads; B waits in EX while A is outstanding
        tick(); ex_ins(5'd10, WbSelLoad, F3Lw, 32'h8000_0004, 32'h0);
        tick(); ex_ins(5'd11, WbSelLoad, F3Lw, 32'h8000_0008, 32'h0);
        wr_n = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) ex_nop();
            mmio_ready = (c == 2) || (c == 4);
            mmio_rdata = (c == 2) ? 32'hAAAA_0001 : ((c == 4) ? 32'hBBBB_0002 : 32'h0);
            @(negedge clk);
            if (wb_we) begin
                if (wr_n < 2) begin
                    wr_addr[wr_n] = wb_addr;
                    wr_data[wr_n] = wb_data;
                end
                wr_n++;
            end
            tick();
        end
        mmio_ready = 1'b0;
        chk("b2b_writes", 32'(wr_n), 32'd2);
        chk("b2b_addr0", 32'(wr_addr[0]), 32'd10);
        chk("b2b_data0", wr_data[0], 32'hAAAA_0001);
        chk("b2b_addr1", 32'(wr_addr[1]), 32'd11);
        chk("b2b_data1", wr_data[1], 32'hBBBB_0002);

        // Reset in the second wait cycle abandons the access
        ex_ins(5'd12, WbSelLoad, F3Lw, 32'h8000_0000, 32'h0);
        tick(); ex_nop();
        tick();
        tick(); rst = 1'b1; mmio_ready = 1'b1; mmio_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstw_no_write", 32'(wb_we), 32'd0);
        tick(); rst = 1'b0; mmio_ready = 1'b0;
        @(negedge clk);
        chk("rstw_req", 32'(mmio_req), 32'd0);
        chk("rstw_we", 32'(wb_we), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        tick(); ex_ins(5'd13, WbSelAlu, 3'd0, 32'h0000_0055, 32'h0);
        tick(); ex_nop();
        @(negedge clk);
        chk("rstw_after_we", 32'(wb_we), 32'd1);
        chk("rstw_after_data", wb_data, 32'h0000_0055);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
